median3x3_stream_ctrl: RTL and testbench

Stream controller that turns a raster pixel stream into 3×3 windows, sequences the team's pipelined 9-tap median network (`midianFilter9`), and returns the filtered interior pixels on a valid/ready output. It owns the line buffers, frame counters, pipeline enable and output skid logic, so the filter itself stays purely combinational or register-enabled. It sits between the pixel source and downstream image blocks. Frames start on a `start` pulse, and the controller signals `done` when the frame has fully drained.

---
 rtl/median_pkg.sv | 20 ++
 rtl/median_line_buf.sv | 24 ++
 rtl/median3x3_stream_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_median3x3_stream_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median stream controller.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int unsigned MEDIAN_TAPS = 9;
    localparam int unsigned WIN_DIM     = 3;
    localparam int unsigned TAP_CENTER  = (WIN_DIM / 2) * WIN_DIM + (WIN_DIM / 2);

    // Window tap index: row 0 = oldest line, col 0 = oldest column.
    function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel storage: asynchronous read, read-before-write at the same address.
module median_line_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/median3x3_stream_ctrl.sv
// Raster stream to 3x3 window sequencer for an external median network.
// Optional MEDIAN_EOF_EN adds m_last on the final interior pixel.
module median3x3_stream_ctrl
    import median_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned FILT_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          filt_en,
    output logic [MEDIAN_TAPS*DATA_W-1:0] win_out,
    input  logic [DATA_W-1:0]             median_in,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          done
`ifdef MEDIAN_EOF_EN
    ,
    output logic                          m_last
`endif
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_e                               state_q;
    logic [COL_W-1:0]                     col_q;
    logic [ROW_W-1:0]                     row_q;
    logic [MEDIAN_TAPS-1:0][DATA_W-1:0]   win_q;
    logic [MEDIAN_TAPS-1:0][DATA_W-1:0]   win_d;
    logic                                 win_valid_q;
    logic                                 m_valid_q;
    logic [DATA_W-1:0]                    m_data_q;
    logic                                 done_q;
    logic [DATA_W-1:0]                    lb0_rd;
    logic [DATA_W-1:0]                    lb1_rd;

    logic adv;
    logic accept;
    logic last_col;
    logic last_row;
    logic win_hit;
    logic frame_end;
    logic pipe_busy;
    logic pipe_valid_out;
    logic drained;

    // The whole pipe moves together, only when the output slot can take a value.
    assign adv       = !m_valid_q || m_ready;
    assign filt_en   = adv;
    assign s_ready   = ((state_q == FILL) || (state_q == RUN)) && adv;
    assign accept    = s_valid && s_ready;
    assign last_col  = (col_q == COL_W'(IMG_W - 1));
    assign last_row  = (row_q == ROW_W'(IMG_H - 1));
    assign win_hit   = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign frame_end = accept && last_col && last_row;
    assign drained   = !pipe_busy && !win_valid_q && !m_valid_q;

    assign win_out = win_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign done    = done_q;

    median_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (COL_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (s_data),
        .rdata (lb0_rd)
    );

    median_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Shift window left; new right column is {two lines ago, one line ago, current}.
    always_comb begin
        win_d = win_q;
        for (int unsigned r = 0; r < WIN_DIM; r++) begin
            win_d[tap_idx(r, 0)] = win_q[tap_idx(r, 1)];
            win_d[tap_idx(r, 1)] = win_q[tap_idx(r, 2)];
        end
        win_d[tap_idx(0, 2)] = lb1_rd;
        win_d[tap_idx(1, 2)] = lb0_rd;
        win_d[tap_idx(2, 2)] = s_data;
    end

    generate
        if (FILT_LAT > 0) begin : g_vpipe
            logic [FILT_LAT-1:0] vp_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vp_q <= '0;
                end else if (adv) begin
                    vp_q <= FILT_LAT'({vp_q, win_valid_q});
                end
            end
            assign pipe_valid_out = vp_q[FILT_LAT-1];
            assign pipe_busy      = |vp_q;
        end else begin : g_no_vpipe
            assign pipe_valid_out = win_valid_q;
            assign pipe_busy      = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (accept && last_col && (row_q == ROW_W'(1))) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (frame_end) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                win_q <= win_d;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            // Bubbles flow through as invalid slots while the window holds.
            if (accept) begin
                win_valid_q <= win_hit;
            end else if (adv) begin
                win_valid_q <= 1'b0;
            end

            if (adv) begin
                m_valid_q <= pipe_valid_out;
                m_data_q  <= median_in;
            end
        end
    end

`ifdef MEDIAN_EOF_EN
    logic win_last_q;
    logic last_out;
    logic m_last_q;

    generate
        if (FILT_LAT > 0) begin : g_lpipe
            logic [FILT_LAT-1:0] lp_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lp_q <= '0;
                end else if (adv) begin
                    lp_q <= FILT_LAT'({lp_q, win_last_q});
                end
            end
            assign last_out = lp_q[FILT_LAT-1];
        end else begin : g_no_lpipe
            assign last_out = win_last_q;
        end
    endgenerate

    // End-of-frame marker rides alongside the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_last_q <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            if (accept) begin
                win_last_q <= frame_end;
            end else if (adv) begin
                win_last_q <= 1'b0;
            end
            if (adv) begin
                m_last_q <= last_out;
            end
        end
    end

    assign m_last = m_last_q;
`endif

endmodule

// File: tb/tb_median3x3_stream_ctrl.sv
// Directed bench for median3x3_stream_ctrl on a 4x4 frame with a behavioural median network.
module tb_median3x3_stream_ctrl;
    import median_pkg::*;

    localparam int NPIX = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        filt_en;
    logic [71:0] win_out;
    logic [7:0]  median_in;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        done;
`ifdef MEDIAN_EOF_EN
    logic        m_last;
`endif

    median3x3_stream_ctrl #(
        .DATA_W   (8),
        .IMG_W    (4),
        .IMG_H    (4),
        .FILT_LAT (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .filt_en   (filt_en),
        .win_out   (win_out),
        .median_in (median_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .done      (done)
`ifdef MEDIAN_EOF_EN
        ,
        .m_last    (m_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] med9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    assign median_in = med9(win_out);

    int         compared;
    int         mismatched;
    logic [7:0] pix [NPIX];
    logic [7:0] got_q [$];
    logic       last_q [$];
    int         done_cnt;
    int         lat;
    logic [7:0] exp_ramp [4] = '{8'd5, 8'd6, 8'd9, 8'd10};

    task automatic load_ramp();
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(i);
    endtask

    // Drives one frame; records outputs, done pulses and latency. Checks stall/done rules inline.
    task automatic run_frame(input bit bubble, input bit stall, input bit mid_start,
                             input int rst_at, output bit aborted);
        int idx = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stall_done = 0;
        int acc_cycle = -1;
        int first_out = -1;
        bit done_flag = 0;
        logic [7:0] held = 8'd0;
        aborted  = 0;
        got_q.delete();
        last_q.delete();
        done_cnt = 0;
        lat      = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done_flag && cyc < 300) begin
            s_valid = (idx < NPIX) && (!bubble || (cyc % 2 == 0));
            s_data  = pix[(idx < NPIX) ? idx : 0];
            if (stall && !stall_done && got_q.size() == 1) begin
                stall_left = 5;
                stall_done = 1;
            end
            m_ready = (stall_left == 0);
            start   = mid_start && (idx == 10);
            rst     = (rst_at >= 0) && (idx == rst_at);
            @(negedge clk);
            if (rst) begin
                @(posedge clk); #1;
                rst = 1'b0; s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
                @(negedge clk);
                aborted = 1;
                return;
            end
            if (s_valid && s_ready) begin
                if (idx == 10) acc_cycle = cyc;
                idx++;
            end
            if (m_valid && !m_ready) begin
                if (stall_left == 5) held = m_data;
                else begin
                    compared++;
                    if (m_data !== held) begin
                        mismatched++;
                        $display("FAIL stall_hold: m_data=%0d required %0d", m_data, held);
                    end
                end
                compared++;
                if (s_ready !== 1'b0 || filt_en !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_ready: s_ready=%b filt_en=%b required 0 0", s_ready, filt_en);
                end
            end
            if (m_valid && m_ready) begin
                if (first_out < 0) first_out = cyc;
                got_q.push_back(m_data);
`ifdef MEDIAN_EOF_EN
                last_q.push_back(m_last);
`endif
            end
            if (done) begin
                done_cnt++;
                done_flag = 1;
                compared++;
                if (m_valid !== 1'b0 || got_q.size() != 4) begin
                    mismatched++;
                    $display("FAIL done_timing: m_valid=%b outputs=%0d required 0 and 4", m_valid, got_q.size());
                end
            end
            if (stall_left > 0) stall_left--;
            cyc++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; m_ready = 1'b1; start = 1'b0;
        compared++;
        if (!done_flag) begin
            mismatched++;
            $display("FAIL frame_timeout: no done after %0d cycles, required done", cyc);
        end
        if (acc_cycle >= 0 && first_out >= 0) lat = first_out - acc_cycle;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: s_ready=%b m_valid=%b done=%b required 000", s_ready, m_valid, done);
        end
        compared++;
        if (m_data !== 8'd0 || win_out !== 72'd0) begin
            mismatched++;
            $display("FAIL reset_data: m_data=%0d win_out=%h required 0 0", m_data, win_out);
        end
        compared++;
        if (dut.state_q !== IDLE || filt_en !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_state: state=%0d filt_en=%b required 0 1", dut.state_q, filt_en);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if (s_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_s_ready: got %b required 0", s_ready);
        end
    endtask

    task automatic test_ramp();
        bit ab;
        load_ramp();
        run_frame(0, 0, 0, -1, ab);
        compared++;
        if (got_q.size() != 4) begin
            mismatched++;
            $display("FAIL ramp_count: got %0d required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_ramp[i]) begin
                mismatched++;
                $display("FAIL ramp_out%0d: got %0d required %0d", i, got_q[i], exp_ramp[i]);
            end
        end
        compared++;
        if (lat != 2) begin
            mismatched++;
            $display("FAIL ramp_latency: got %0d required 2", lat);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || done_cnt != 1 || dut.state_q !== IDLE) begin
            mismatched++;
            $display("FAIL done_pulse: done=%b count=%0d state=%0d required 0 1 0", done, done_cnt, dut.state_q);
        end
    endtask

    task automatic test_impulse();
        bit ab;
        for (int i = 0; i < NPIX; i++) pix[i] = 8'd10;
        pix[5] = 8'd255;
        run_frame(0, 0, 0, -1, ab);
        compared++;
        if (got_q.size() != 4) begin
            mismatched++;
            $display("FAIL impulse_count: got %0d required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== 8'd10) begin
                mismatched++;
                $display("FAIL impulse_out%0d: got %0d required 10", i, got_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ab;
        load_ramp();
        run_frame(0, 1, 0, -1, ab);
        compared++;
        if (got_q.size() != 4) begin
            mismatched++;
            $display("FAIL bp_count: got %0d required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_ramp[i]) begin
                mismatched++;
                $display("FAIL bp_out%0d: got %0d required %0d", i, got_q[i], exp_ramp[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        bit ab;
        load_ramp();
        run_frame(1, 0, 0, -1, ab);
        compared++;
        if (got_q.size() != 4 || done_cnt != 1) begin
            mismatched++;
            $display("FAIL bubble_count: outputs=%0d done=%0d required 4 1", got_q.size(), done_cnt);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_ramp[i]) begin
                mismatched++;
                $display("FAIL bubble_out%0d: got %0d required %0d", i, got_q[i], exp_ramp[i]);
            end
        end
    endtask

    task automatic test_start_in_run();
        bit ab;
        load_ramp();
        run_frame(0, 0, 1, -1, ab);
        compared++;
        if (got_q.size() != 4 || done_cnt != 1) begin
            mismatched++;
            $display("FAIL start_run_count: outputs=%0d done=%0d required 4 1", got_q.size(), done_cnt);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_ramp[i]) begin
                mismatched++;
                $display("FAIL start_run_out%0d: got %0d required %0d", i, got_q[i], exp_ramp[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ab;
        int bad = 0;
        load_ramp();
        run_frame(0, 0, 0, 6, ab);
        compared++;
        if (!ab) begin
            mismatched++;
            $display("FAIL abort_reached: got %b required 1", ab);
        end
        compared++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || m_data !== 8'd0 ||
            win_out !== 72'd0 || dut.state_q !== IDLE) begin
            mismatched++;
            $display("FAIL abort_state: m_valid=%b s_ready=%b done=%b m_data=%0d state=%0d required all 0",
                     m_valid, s_ready, done, m_data, dut.state_q);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid || done) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL abort_quiet: %0d cycles with m_valid/done, required 0", bad);
        end
        run_frame(0, 0, 0, -1, ab);
        compared++;
        if (got_q.size() != 4) begin
            mismatched++;
            $display("FAIL after_abort_count: got %0d required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_ramp[i]) begin
                mismatched++;
                $display("FAIL after_abort_out%0d: got %0d required %0d", i, got_q[i], exp_ramp[i]);
            end
        end
    endtask

`ifdef MEDIAN_EOF_EN
    task automatic test_eof();
        bit ab;
        load_ramp();
        run_frame(0, 0, 0, -1, ab);
        compared++;
        if (last_q.size() != 4) begin
            mismatched++;
            $display("FAIL eof_count: got %0d required 4", last_q.size());
        end
        for (int i = 0; i < last_q.size(); i++) begin
            compared++;
            if (last_q[i] !== (i == 3)) begin
                mismatched++;
                $display("FAIL eof_last%0d: got %b required %b", i, last_q[i], (i == 3));
            end
        end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        test_reset();
        test_ramp();
        test_impulse();
        test_backpressure();
        test_bubbles();
        test_start_in_run();
        test_reset_abort();
`ifdef MEDIAN_EOF_EN
        test_eof();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
